// File: rtl/ems_pkg.sv
// Shared definitions for the EMS page loader: state encoding, page geometry
// and the byte-lane select driven on every WISHBONE cycle.
package ems_pkg;

    localparam int         EMS_NUM_PAGES = 4;
    localparam int         EMS_PAGE_W    = 8;
    localparam logic [1:0] EMS_LANE_SEL  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FINISH = 3'd5
    } ems_state_e;

    // Register n of the page table lives in byte lane n.
    function automatic logic [EMS_PAGE_W-1:0] page_byte(
        input logic [EMS_NUM_PAGES*EMS_PAGE_W-1:0] pages,
        input logic [1:0]                          idx
    );
        page_byte = pages[{idx, 3'b000} +: EMS_PAGE_W];
    endfunction

endpackage

// File: rtl/ems_wb_watchdog.sv
// Per-cycle ack watchdog: counts edges with stb high and no ack, and flags
// expiry on the edge that would make the count reach TIMEOUT.
import ems_pkg::*;

module ems_wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_expired
);

    logic [7:0] r_cnt;

    // Edge counter, held at zero whenever no cycle is outstanding.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_stb && !i_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = i_stb && !i_ack && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ems_page_loader.sv
// WISHBONE initiator that writes four EMS page registers from a packed table
// and optionally reads them back, with a per-cycle ack watchdog.
import ems_pkg::*;

module ems_page_loader #(
    parameter bit VERIFY  = 1'b1,
    parameter int TIMEOUT = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start_i,
    input  logic [31:0] pages_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_idx_o,
    output logic [1:0]  wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i
);

    ems_state_e  r_state;
    logic [31:0] r_pages;
    logic [1:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_idx;
    logic        r_stb;
    logic        r_we;
    logic [1:0]  r_sel;
    logic [15:0] r_dat;

    logic [1:0]  w_next_idx;
    logic [7:0]  w_cur_byte;
    logic [7:0]  w_next_byte;
    logic        w_mismatch;
    logic        w_expired;

    assign w_next_idx  = r_idx + 2'd1;
    assign w_cur_byte  = page_byte(r_pages, r_idx);
    assign w_next_byte = page_byte(r_pages, w_next_idx);
    // Only the low byte lane carries register data.
    assign w_mismatch  = (wb_dat_i & 16'h00FF) != {8'h00, w_cur_byte};

    ems_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (wb_clk),
        .i_rst     (wb_rst),
        .i_clear   (!r_stb),
        .i_stb     (r_stb),
        .i_ack     (wb_ack_i),
        .o_expired (w_expired)
    );

    // Sequencer: every WISHBONE output is a register updated here.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state   <= ST_IDLE;
            r_pages   <= 32'h0000_0000;
            r_idx     <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= 2'd0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 2'b00;
            r_dat     <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_pages   <= pages_i;
                        r_err     <= 1'b0;
                        r_err_idx <= 2'd0;
                        r_idx     <= 2'd0;
                        r_state   <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    // Entry from IDLE arrives with stb low: open the first cycle.
                    if (!r_stb) begin
                        r_busy <= 1'b1;
                        r_stb  <= 1'b1;
                        r_sel  <= EMS_LANE_SEL;
                        r_we   <= (r_state == ST_WR_REQ);
                        r_dat  <= {8'h00, w_cur_byte};
                    end else if (wb_ack_i) begin
                        r_stb <= 1'b0;
                        r_sel <= 2'b00;
                        r_we  <= 1'b0;
                        r_dat <= 16'h0000;
                        if (r_state == ST_RD_REQ) begin
                            if (w_mismatch && !r_err) begin
                                r_err     <= 1'b1;
                                r_err_idx <= r_idx;
                            end
                            r_state <= ST_RD_GAP;
                        end else begin
                            r_state <= ST_WR_GAP;
                        end
                    end else if (w_expired) begin
                        r_stb  <= 1'b0;
                        r_sel  <= 2'b00;
                        r_we   <= 1'b0;
                        r_dat  <= 16'h0000;
                        if (!r_err) begin
                            r_err     <= 1'b1;
                            r_err_idx <= r_idx;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_WR_GAP: begin
                    if (r_idx != 2'd3) begin
                        r_idx   <= w_next_idx;
                        r_stb   <= 1'b1;
                        r_sel   <= EMS_LANE_SEL;
                        r_we    <= 1'b1;
                        r_dat   <= {8'h00, w_next_byte};
                        r_state <= ST_WR_REQ;
                    end else if (VERIFY) begin
                        r_idx   <= 2'd0;
                        r_stb   <= 1'b1;
                        r_sel   <= EMS_LANE_SEL;
                        r_we    <= 1'b0;
                        r_dat   <= 16'h0000;
                        r_state <= ST_RD_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_RD_GAP: begin
                    if (r_idx != 2'd3) begin
                        r_idx   <= w_next_idx;
                        r_stb   <= 1'b1;
                        r_sel   <= EMS_LANE_SEL;
                        r_we    <= 1'b0;
                        r_dat   <= 16'h0000;
                        r_state <= ST_RD_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign err_idx_o = r_err_idx;
    assign wb_adr_o  = r_idx;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_cyc_o  = r_stb;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;

endmodule

// File: tb/tb_ems_page_loader.sv
// Directed bench: two loaders (verify on / verify off), each behind a small
// model of the ems responder that acks one cycle late and holds ack one extra cycle.
module tb_ems_page_loader;

    logic wb_clk = 1'b0;
    logic wb_rst;
    always #5 wb_clk = ~wb_clk;

    logic        start_i   [2];
    logic [31:0] pages_i   [2];
    logic        busy_o    [2];
    logic        done_o    [2];
    logic        err_o     [2];
    logic [1:0]  err_idx_o [2];
    logic [1:0]  wb_adr_o  [2];
    logic [15:0] wb_dat_o  [2];
    logic [15:0] wb_dat_i  [2];
    logic [1:0]  wb_sel_o  [2];
    logic        wb_cyc_o  [2];
    logic        wb_stb_o  [2];
    logic        wb_we_o   [2];
    logic        wb_ack_i  [2];

    ems_page_loader #(.VERIFY(1'b1), .TIMEOUT(16)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .start_i(start_i[0]), .pages_i(pages_i[0]),
        .busy_o(busy_o[0]), .done_o(done_o[0]), .err_o(err_o[0]), .err_idx_o(err_idx_o[0]),
        .wb_adr_o(wb_adr_o[0]), .wb_dat_o(wb_dat_o[0]), .wb_dat_i(wb_dat_i[0]),
        .wb_sel_o(wb_sel_o[0]), .wb_cyc_o(wb_cyc_o[0]), .wb_stb_o(wb_stb_o[0]),
        .wb_we_o(wb_we_o[0]), .wb_ack_i(wb_ack_i[0]));

    ems_page_loader #(.VERIFY(1'b0), .TIMEOUT(16)) dut_nv (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .start_i(start_i[1]), .pages_i(pages_i[1]),
        .busy_o(busy_o[1]), .done_o(done_o[1]), .err_o(err_o[1]), .err_idx_o(err_idx_o[1]),
        .wb_adr_o(wb_adr_o[1]), .wb_dat_o(wb_dat_o[1]), .wb_dat_i(wb_dat_i[1]),
        .wb_sel_o(wb_sel_o[1]), .wb_cyc_o(wb_cyc_o[1]), .wb_stb_o(wb_stb_o[1]),
        .wb_we_o(wb_we_o[1]), .wb_ack_i(wb_ack_i[1]));

    // Responder model
    logic [7:0] mem [2][4];
    logic       no_ack  = 1'b0;
    int         bad_idx = -1;

    always @(posedge wb_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wb_rst) begin
                wb_ack_i[d] <= 1'b0;
                for (int r = 0; r < 4; r++) mem[d][r] <= 8'h00;
            end else begin
                wb_ack_i[d] <= wb_stb_o[d] && !no_ack;
                if (wb_stb_o[d] && wb_cyc_o[d] && wb_we_o[d] && wb_ack_i[d] && wb_sel_o[d] == 2'b01)
                    mem[d][wb_adr_o[d]] <= wb_dat_o[d][7:0];
            end
        end
    end

    // High byte is junk on purpose: only the low lane may be compared.
    always_comb begin
        wb_dat_i[0] = (bad_idx == int'(wb_adr_o[0])) ? 16'h5AFF : {8'h5A, mem[0][wb_adr_o[0]]};
        wb_dat_i[1] = {8'h5A, mem[1][wb_adr_o[1]]};
    end

    // Bus monitor
    int         edge_cnt = 0;
    int         rise_edge [2][64];
    logic [1:0] rise_adr  [2][64];
    logic       rise_we   [2][64];
    logic [15:0] rise_dat [2][64];
    logic [1:0] rise_sel  [2][64];
    int         n_rise    [2] = '{0, 0};
    int         fall_edge [2] = '{0, 0};
    int         done_edge [2] = '{0, 0};
    int         n_done    [2] = '{0, 0};
    logic       busy_at_done [2] = '{1'b0, 1'b0};
    logic       prev_stb  [2] = '{1'b0, 1'b0};

    always @(posedge wb_clk) edge_cnt <= edge_cnt + 1;

    always @(negedge wb_clk) begin
        for (int d = 0; d < 2; d++) begin
            prev_stb[d] <= wb_stb_o[d];
            if (wb_stb_o[d] && !prev_stb[d] && n_rise[d] < 64) begin
                rise_edge[d][n_rise[d]] <= edge_cnt;
                rise_adr[d][n_rise[d]]  <= wb_adr_o[d];
                rise_we[d][n_rise[d]]   <= wb_we_o[d];
                rise_dat[d][n_rise[d]]  <= wb_dat_o[d];
                rise_sel[d][n_rise[d]]  <= wb_sel_o[d];
                n_rise[d] <= n_rise[d] + 1;
            end
            if (!wb_stb_o[d] && prev_stb[d]) fall_edge[d] <= edge_cnt;
            if (done_o[d]) begin
                done_edge[d]    <= edge_cnt;
                busy_at_done[d] <= busy_o[d];
                n_done[d]       <= n_done[d] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge wb_clk);
        #1;
    endtask

    function automatic logic [31:0] outs(input int d);
        return {4'h0, busy_o[d], done_o[d], err_o[d], err_idx_o[d], wb_adr_o[d],
                wb_dat_o[d], wb_sel_o[d], wb_cyc_o[d], wb_stb_o[d], wb_we_o[d]};
    endfunction

    task automatic start_seq(input int d, input logic [31:0] pages, output int n);
        start_i[d] = 1'b1;
        pages_i[d] = pages;
        tick();
        n = edge_cnt;
        start_i[d] = 1'b0;
        pages_i[d] = 32'h0000_0000;
    endtask

    task automatic wait_done(input int d, input int base, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (n_done[d] > base) break;
            tick();
        end
        check({tag, "_done_seen"}, 32'(n_done[d] > base), 32'd1);
    endtask

    task automatic check_xfers(input int d, input int base, input int n, input int cnt,
                               input logic [31:0] pages, input string tag);
        logic [7:0] b;
        for (int k = 0; k < cnt; k++) begin
            b = pages[8*(k%4) +: 8];
            check($sformatf("%s_x%0d_edge", tag, k), 32'(rise_edge[d][base+k]), 32'(n + 1 + 3*k));
            check($sformatf("%s_x%0d_adr", tag, k), 32'(rise_adr[d][base+k]), 32'(k % 4));
            check($sformatf("%s_x%0d_we", tag, k), 32'(rise_we[d][base+k]), 32'(k < 4));
            check($sformatf("%s_x%0d_sel", tag, k), 32'(rise_sel[d][base+k]), 32'd1);
            if (k < 4)
                check($sformatf("%s_x%0d_dat", tag, k), 32'(rise_dat[d][base+k]), {24'h0, b});
        end
    endtask

    int n, br, bd;

    initial begin
        wb_rst = 1'b1;
        start_i = '{1'b0, 1'b0};
        pages_i = '{32'h0, 32'h0};
        repeat (3) tick();
        check("reset_outs_v", outs(0), 32'h0);
        check("reset_outs_nv", outs(1), 32'h0);
        wb_rst = 1'b0;
        tick();

        // Timeout: responder never acks
        no_ack = 1'b1;
        br = n_rise[0]; bd = n_done[0];
        start_seq(0, 32'h0F0E0D0C, n);
        wait_done(0, bd, "to");
        check("to_stb_fall_edge", 32'(fall_edge[0]), 32'(n + 17));
        check("to_done_edge", 32'(done_edge[0]), 32'(n + 17));
        check("to_err", 32'(err_o[0]), 32'd1);
        check("to_err_idx", 32'(err_idx_o[0]), 32'd0);
        repeat (20) tick();
        check("to_single_cycle", 32'(n_rise[0] - br), 32'd1);
        check("to_err_held", 32'(err_o[0]), 32'd1);
        no_ack = 1'b0;

        // Clean verify run with ignored starts at N+5 and in the done cycle
        br = n_rise[0]; bd = n_done[0];
        start_seq(0, 32'h0F0E0D0C, n);
        check("ok_err_cleared", 32'(err_o[0]), 32'd0);
        repeat (4) tick();
        start_i[0] = 1'b1; pages_i[0] = 32'hDEADBEEF;
        tick();
        start_i[0] = 1'b0;
        check("ok_busy_mid", 32'(busy_o[0]), 32'd1);
        wait_done(0, bd, "ok");
        start_i[0] = 1'b1; pages_i[0] = 32'hDEADBEEF;
        tick();
        start_i[0] = 1'b0;
        check("ok_done_edge", 32'(done_edge[0]), 32'(n + 25));
        check("ok_busy_at_done", 32'(busy_at_done[0]), 32'd0);
        check("ok_err", 32'(err_o[0]), 32'd0);
        repeat (10) tick();
        check("ok_cycles", 32'(n_rise[0] - br), 32'd8);
        check("ok_one_done", 32'(n_done[0] - bd), 32'd1);
        check("ok_idle_after", 32'(busy_o[0]), 32'd0);
        check_xfers(0, br, n, 8, 32'h0F0E0D0C, "ok");

        // Verify mismatch on register 2
        bad_idx = 2;
        br = n_rise[0]; bd = n_done[0];
        start_seq(0, 32'h0F0E0D0C, n);
        wait_done(0, bd, "mm");
        check("mm_done_edge", 32'(done_edge[0]), 32'(n + 25));
        check("mm_err", 32'(err_o[0]), 32'd1);
        check("mm_err_idx", 32'(err_idx_o[0]), 32'd2);
        repeat (3) tick();
        check("mm_cycles", 32'(n_rise[0] - br), 32'd8);
        bad_idx = -1;

        // Write-only instance
        br = n_rise[1]; bd = n_done[1];
        start_seq(1, 32'hA1B2C3D4, n);
        wait_done(1, bd, "nv");
        check("nv_done_edge", 32'(done_edge[1]), 32'(n + 13));
        check("nv_err", 32'(err_o[1]), 32'd0);
        repeat (5) tick();
        check("nv_cycles", 32'(n_rise[1] - br), 32'd4);
        check_xfers(1, br, n, 4, 32'hA1B2C3D4, "nv");

        // Reset during the third write
        br = n_rise[0]; bd = n_done[0];
        start_seq(0, 32'h0F0E0D0C, n);
        for (int i = 0; i < 50; i++) begin
            if (n_rise[0] - br >= 3) break;
            tick();
        end
        check("rst_mid_stb_high", 32'(wb_stb_o[0]), 32'd1);
        wb_rst = 1'b1;
        tick();
        check("rst_mid_outs", outs(0), 32'h0);
        wb_rst = 1'b0;
        repeat (30) tick();
        check("rst_no_done", 32'(n_done[0] - bd), 32'd0);
        check("rst_idle", outs(0), 32'h0);
        br = n_rise[0]; bd = n_done[0];
        start_seq(0, 32'h0F0E0D0C, n);
        wait_done(0, bd, "rr");
        check("rr_done_edge", 32'(done_edge[0]), 32'(n + 25));
        check("rr_err", 32'(err_o[0]), 32'd0);
        check("rr_cycles", 32'(n_rise[0] - br), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
